// File: rtl/ringosc_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
package ringosc_pkg;

   localparam int OSC_CNT_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam logic [OSC_CNT_W-1:0] CNT_MIN_RST = '1;
   localparam logic [OSC_CNT_W-1:0] CNT_MAX_RST = '0;

endpackage

// File: rtl/ringosc_cnt_sync.sv
// Brings the free-running oscillator count into clk through two flops and
// flags when two consecutive synchronized samples agree, or when sampling times out.
module ringosc_cnt_sync
   import ringosc_pkg::*;
#(
   parameter int TMO_CYC = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [OSC_CNT_W-1:0] osc_cnt,
   output logic                 valid,
   output logic                 match,
   output logic                 timeout,
   output logic [OSC_CNT_W-1:0] value
);

   localparam int TW = $clog2(TMO_CYC + 1);

   logic [OSC_CNT_W-1:0] sync1, sync2, prev;
   logic [TW-1:0]        cyc;

   // The synchronizer free-runs, so the capture from the last settle cycle
   // is already through both flops and serves as the first comparison partner.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
         cyc   <= '0;
      end else begin
         sync1 <= osc_cnt;
         sync2 <= sync1;
         prev  <= sync2;
         cyc   <= en ? cyc + TW'(1) : '0;
      end
   end

   assign valid   = en && (cyc >= TW'(2));
   assign match   = valid && (sync2 == prev);
   assign timeout = en && !match && (cyc == TW'(TMO_CYC - 1));
   assign value   = sync2;

endmodule

// File: rtl/ringosc_meas_ctrl.sv
// Ring-oscillator measurement sequencer: clear, gated run, settle, safe readback.
// Define RINGOSC_MEAS_MINMAX_EN to add running min/max tracking of good counts.
module ringosc_meas_ctrl
   import ringosc_pkg::*;
#(
   parameter int GATE_W     = 24,
   parameter int CLR_CYC    = 4,
   parameter int SETTLE_CYC = 8,
   parameter int TMO_CYC    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [GATE_W-1:0]    gate_len,
   input  logic [OSC_CNT_W-1:0] osc_cnt,
   output logic                 osc_rst,
   output logic                 osc_halt,
   output logic                 busy,
   output logic                 done,
   output logic [OSC_CNT_W-1:0] count,
   output logic                 err
`ifdef RINGOSC_MEAS_MINMAX_EN
   ,
   input  logic                 stats_clr,
   output logic [OSC_CNT_W-1:0] cnt_min,
   output logic [OSC_CNT_W-1:0] cnt_max
`endif
);

   localparam logic [GATE_W-1:0] CLR_LAST = GATE_W'(CLR_CYC - 1);
   localparam logic [GATE_W-1:0] SET_LAST = GATE_W'(SETTLE_CYC - 1);

   state_t               state, state_nxt;
   logic [GATE_W-1:0]    gate_q, tmr, tmr_nxt, run_last;
   logic                 samp_en, s_valid, s_match, s_timeout;
   logic [OSC_CNT_W-1:0] s_value;

   // A zero gate length still opens the window for one cycle.
   assign run_last = (gate_q == '0) ? '0 : gate_q - GATE_W'(1);

   ringosc_cnt_sync #(.TMO_CYC(TMO_CYC)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .en      (samp_en),
      .osc_cnt (osc_cnt),
      .valid   (s_valid),
      .match   (s_match),
      .timeout (s_timeout),
      .value   (s_value)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         tmr    <= '0;
         gate_q <= '0;
         count  <= '0;
         err    <= 1'b0;
      end else begin
         state <= state_nxt;
         tmr   <= tmr_nxt;
         if (state == ST_IDLE && start)
            gate_q <= gate_len;
         if (state == ST_SAMPLE && s_valid && s_match) begin
            count <= s_value;
            err   <= 1'b0;
         end else if (state == ST_SAMPLE && s_timeout) begin
            count <= s_value;
            err   <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr + GATE_W'(1);
      osc_rst   = 1'b0;
      osc_halt  = 1'b1;
      busy      = 1'b0;
      done      = 1'b0;
      samp_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            tmr_nxt = '0;
            if (start)
               state_nxt = ST_CLEAR;
         end
         ST_CLEAR: begin
            osc_rst = 1'b1;
            busy    = 1'b1;
            if (tmr == CLR_LAST) begin
               state_nxt = ST_RUN;
               tmr_nxt   = '0;
            end
         end
         ST_RUN: begin
            osc_halt = 1'b0;
            busy     = 1'b1;
            if (tmr == run_last) begin
               state_nxt = ST_SETTLE;
               tmr_nxt   = '0;
            end
         end
         ST_SETTLE: begin
            busy = 1'b1;
            if (tmr == SET_LAST) begin
               state_nxt = ST_SAMPLE;
               tmr_nxt   = '0;
            end
         end
         ST_SAMPLE: begin
            busy    = 1'b1;
            samp_en = 1'b1;
            if ((s_valid && s_match) || s_timeout)
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef RINGOSC_MEAS_MINMAX_EN
   // Only stable readings feed the extrema; a clear in the done cycle wins.
   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         cnt_min <= CNT_MIN_RST;
         cnt_max <= CNT_MAX_RST;
      end else if (done && !err) begin
         if (count < cnt_min) cnt_min <= count;
         if (count > cnt_max) cnt_max <= count;
      end
   end
`endif

endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// Scoreboard bench for ringosc_meas_ctrl with a behavioural oscillator (7 ticks/clk).
module tb_ringosc_meas_ctrl;

   localparam int GATE_W = 24;
   localparam int CLR    = 4;
   localparam int SET    = 8;
   localparam int TMO    = 16;
   localparam int TICK   = 7;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [GATE_W-1:0] gate_len = '0;
   logic [31:0]       osc_cnt = '0;
   logic              osc_rst, osc_halt, busy, done, err;
   logic [31:0]       count;
`ifdef RINGOSC_MEAS_MINMAX_EN
   logic              stats_clr = 1'b0;
   logic [31:0]       cnt_min, cnt_max;
   longint            exp_min = 64'hFFFF_FFFF;
   longint            exp_max = 0;
`endif

   ringosc_meas_ctrl #(
      .GATE_W(GATE_W), .CLR_CYC(CLR), .SETTLE_CYC(SET), .TMO_CYC(TMO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .gate_len(gate_len), .osc_cnt(osc_cnt),
      .osc_rst(osc_rst), .osc_halt(osc_halt), .busy(busy), .done(done),
      .count(count), .err(err)
`ifdef RINGOSC_MEAS_MINMAX_EN
      , .stats_clr(stats_clr), .cnt_min(cnt_min), .cnt_max(cnt_max)
`endif
   );

   always #5 clk = ~clk;

   // Oscillator: cleared by osc_rst, counts while released or while stuck.
   bit stuck = 1'b0;
   always @(posedge clk) begin
      if (osc_rst)                osc_cnt <= '0;
      else if (!osc_halt || stuck) osc_cnt <= osc_cnt + TICK;
   end

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      longint      cnt;
      logic        err;
      int unsigned done_cyc;
      int          halt_low;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   halt_low = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (done) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: done pulse with no accepted start (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("count", count, e.cnt);
            chk("err", err, e.err);
            chk("done_cycle", cyc, e.done_cyc);
            chk("halt_low_cycles", halt_low, e.halt_low);
            chk("busy_in_done", busy, 0);
         end
         halt_low = 0;
      end else if (!busy) begin
         halt_low = 0;
      end else if (!osc_halt) begin
         halt_low++;
      end
   end

   // One accepted start; expectations come from the run window, settle,
   // two-flop readback and the timeout rule.
   task automatic launch(input int g, input bit stk, input bit pokes);
      exp_t        e;
      int          geff;
      int          w;
      int unsigned t;
      geff = (g == 0) ? 1 : g;
      @(negedge clk);
      stuck    = stk;
      gate_len = GATE_W'(g);
      start    = 1'b1;
      t        = cyc;
      e.done_cyc = t + 1 + CLR + geff + SET + (stk ? TMO : 3);
      e.cnt      = stk ? TICK * (geff + SET + TMO - 3) : TICK * geff;
      e.err      = stk;
      e.halt_low = geff;
      sb.push_back(e);
`ifdef RINGOSC_MEAS_MINMAX_EN
      if (!stk) begin
         if (e.cnt < exp_min) exp_min = e.cnt;
         if (e.cnt > exp_max) exp_max = e.cnt;
      end
`endif
      @(negedge clk);
      start    = 1'b0;
      gate_len = GATE_W'($urandom);
      chk("busy_after_start", busy, 1);
      chk("osc_rst_after_start", osc_rst, 1);
      if (pokes) begin
         for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(1, 10)) @(negedge clk);
            if (busy) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      end
      w = 0;
      while (sb.size() != 0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL done_timeout: no done within 2000 cycles of start at cycle %0d", t);
         sb.delete();
      end
      repeat (3) @(negedge clk);
      chk("idle_after_done", busy, 0);
      stuck = 1'b0;
   endtask

`ifdef RINGOSC_MEAS_MINMAX_EN
   task automatic pulse_stats_clr();
      @(negedge clk);
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      exp_min   = 64'hFFFF_FFFF;
      exp_max   = 0;
      chk("min_after_clr", cnt_min, exp_min);
      chk("max_after_clr", cnt_max, exp_max);
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_osc_halt", osc_halt, 1);
      chk("rst_osc_rst", osc_rst, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count, 0);
      chk("rst_err", err, 0);
`ifdef RINGOSC_MEAS_MINMAX_EN
      chk("rst_min", cnt_min, 64'hFFFF_FFFF);
      chk("rst_max", cnt_max, 0);
`endif
      rst = 1'b0;
      repeat (2) @(negedge clk);

      launch(100, 1'b0, 1'b0);
      launch(0, 1'b0, 1'b0);
      launch(20, 1'b1, 1'b0);
      launch(30, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++)
         launch(int'($urandom_range(0, 60)), ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);

`ifdef RINGOSC_MEAS_MINMAX_EN
      chk("min_history", cnt_min, exp_min);
      chk("max_history", cnt_max, exp_max);
      pulse_stats_clr();
      launch(50, 1'b0, 1'b0);
      launch(200, 1'b0, 1'b0);
      launch(100, 1'b0, 1'b0);
      chk("min_3runs", cnt_min, 350);
      chk("max_3runs", cnt_max, 1400);
      launch(15, 1'b1, 1'b0);
      chk("min_err_ignored", cnt_min, 350);
      pulse_stats_clr();
      launch(10, 1'b0, 1'b0);
      chk("min_single", cnt_min, 70);
      chk("max_single", cnt_max, 70);
`endif

      // Reset in the middle of the run window.
      @(negedge clk);
      gate_len = GATE_W'(200);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (CLR + 20) @(negedge clk);
      chk("running_before_rst", osc_halt, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_osc_halt", osc_halt, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_osc_rst", osc_rst, 0);
      chk("midrst_count", count, 0);
      chk("midrst_err", err, 0);
`ifdef RINGOSC_MEAS_MINMAX_EN
      chk("midrst_min", cnt_min, 64'hFFFF_FFFF);
      chk("midrst_max", cnt_max, 0);
`endif
      repeat (300) @(negedge clk);
      chk("midrst_stays_idle", busy, 0);

      // start together with rst must not launch a run.
      @(negedge clk);
      rst      = 1'b1;
      start    = 1'b1;
      gate_len = GATE_W'(5);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      chk("start_rst_busy", busy, 0);
      chk("start_rst_osc_rst", osc_rst, 0);
      repeat (40) @(negedge clk);
      chk("start_rst_idle", busy, 0);

      launch(12, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
